// File: rtl/scan_display_ctrl.sv
// -----------------------------------------------------------------------------
// scan_display_ctrl
//
// Time-multiplexed driver for a four-digit hexadecimal 7-segment display.
// The four nibbles of a 16-bit value share one segment bus. One active-low
// digit enable is pulled low at a time, scanning digits 3, 2, 1, 0.
//
// Before each digit is lit, every enable is held off for BLANK_TICKS cycles.
// This stops ghosting while the segment bus changes between digits.
//
// New values are double-buffered, so a frame never shows half of one value
// and half of another.
//
// Ports:
//   clk        system clock
//   rst        asynchronous, active-high reset
//   en         scan enable; 0 keeps the display dark
//   value_in   value to display (four hex nibbles)
//   load       one-cycle strobe that captures value_in
//   seg_out    shared segment bus, active-low (decoded nibble or BLANK_SEG)
//   an_out     active-low digit enables; an_out[3] shows value[15:12]
//   digit_sel  index of the digit that currently owns the bus
//   pending    a loaded value is waiting for the next frame boundary
//   frame_done one-cycle pulse after each complete 4-digit frame
// -----------------------------------------------------------------------------

// Hex nibble to active-low segment pattern. Bit order is {g,f,e,d,c,b,a}.
module decoder_7_seg (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);
  always_comb begin
    seg = 7'h7F;
    case (nibble)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
  end
endmodule

module scan_display_ctrl #(
  parameter int          N           = 16,
  parameter int          DIGIT_TICKS = 50000,
  parameter int          BLANK_TICKS = 500,
  parameter int          LZ_SUPPRESS = 1,
  parameter logic [6:0]  BLANK_SEG   = 7'h7F
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] value_in,
  input  logic         load,
  output logic [6:0]   seg_out,
  output logic [3:0]   an_out,
  output logic [1:0]   digit_sel,
  output logic         pending,
  output logic         frame_done
);

  localparam int MAXT = (DIGIT_TICKS > BLANK_TICKS) ? DIGIT_TICKS : BLANK_TICKS;
  localparam int CW   = (MAXT > 1) ? $clog2(MAXT) : 1;
  localparam logic [CW-1:0] DIGIT_LAST = CW'(DIGIT_TICKS - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  state_t         state, state_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [1:0]     dsel_n;
  logic [N-1:0]   disp, disp_n;
  logic [N-1:0]   pval, pval_n;
  logic           pend_n;
  logic           frame_end;
  logic [3:0]     nib_n;
  logic [6:0]     dec_seg;
  logic           suppress_n;
  logic [3:0]     an_n;
  logic [6:0]     seg_n;

  // Scan sequencer. Every digit slot is BLANK_TICKS cycles off, then
  // DIGIT_TICKS cycles lit. The 0 -> 3 wrap goes straight into BLANK, so a
  // frame is exactly 4*(BLANK_TICKS+DIGIT_TICKS) cycles.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    dsel_n    = digit_sel;
    frame_end = 1'b0;
    if (!en) begin
      state_n = IDLE;
      cnt_n   = '0;
      dsel_n  = 2'd3;
    end else begin
      case (state)
        IDLE: begin
          state_n = BLANK;
          cnt_n   = '0;
          dsel_n  = 2'd3;
        end
        BLANK: begin
          if (cnt == BLANK_LAST) begin
            state_n = SHOW;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        SHOW: begin
          if (cnt == DIGIT_LAST) begin
            state_n = BLANK;
            cnt_n   = '0;
            if (digit_sel == 2'd0) begin
              frame_end = 1'b1;
              dsel_n    = 2'd3;
            end else begin
              dsel_n = digit_sel - 2'd1;
            end
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
          dsel_n  = 2'd3;
        end
      endcase
    end
  end

  // Load handshake. A load strobe is always accepted; there is no back-pressure.
  // While scanning, the value waits in pval until the frame-end edge. A strobe
  // on the frame-end edge itself bypasses the buffer. The buffer is also
  // bypassed when the display is dark. The newest strobe always wins.
  always_comb begin
    disp_n = disp;
    pval_n = pval;
    pend_n = pending;
    if (load && (!en || frame_end)) begin
      disp_n = value_in;
      pend_n = 1'b0;
    end else if (frame_end && pending) begin
      disp_n = pval;
      pend_n = 1'b0;
    end else if (load) begin
      pval_n = value_in;
      pend_n = 1'b1;
    end
  end

  // The output decode uses the next-cycle values, so every output comes
  // straight from a register and lines up with the state it belongs to.
  always_comb begin
    nib_n = disp_n[3:0];
    case (dsel_n)
      2'd3: nib_n = disp_n[15:12];
      2'd2: nib_n = disp_n[11:8];
      2'd1: nib_n = disp_n[7:4];
      default: nib_n = disp_n[3:0];
    endcase
  end

  decoder_7_seg u_dec (
    .nibble (nib_n),
    .seg    (dec_seg)
  );

  // A digit is a leading zero when it and every digit above it are zero.
  // Digit 0 is never blanked, so a value of 0 still shows "0".
  always_comb begin
    suppress_n = 1'b0;
    if (LZ_SUPPRESS != 0) begin
      case (dsel_n)
        2'd3: suppress_n = (disp_n[15:12] == 4'h0);
        2'd2: suppress_n = (disp_n[15:8] == 8'h00);
        2'd1: suppress_n = (disp_n[15:4] == 12'h000);
        default: suppress_n = 1'b0;
      endcase
    end
  end

  always_comb begin
    an_n  = 4'hF;
    seg_n = BLANK_SEG;
    if (state_n == SHOW) begin
      an_n[dsel_n] = 1'b0;
      seg_n        = suppress_n ? BLANK_SEG : dec_seg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      digit_sel  <= 2'd3;
      disp       <= '0;
      pval       <= '0;
      pending    <= 1'b0;
      an_out     <= 4'hF;
      seg_out    <= BLANK_SEG;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      digit_sel  <= dsel_n;
      disp       <= disp_n;
      pval       <= pval_n;
      pending    <= pend_n;
      an_out     <= an_n;
      seg_out    <= seg_n;
      frame_done <= frame_end;
    end
  end

endmodule

// File: tb/tb_scan_display_ctrl.sv
// -----------------------------------------------------------------------------
// tb_scan_display_ctrl
//
// Stimulus task:
//   The driver pushes the {digit, segment} pattern expected for each digit
//   slot of a frame into exp_q. It does this before the slot lights up.
//
// Negedge monitor:
//   Pops one entry at the first lit cycle of every digit and compares it.
//   Checks the lit-length timing and the blank-gap timing.
//   Checks that at most one digit is enabled in every cycle.
// -----------------------------------------------------------------------------
module tb_scan_display_ctrl;

  localparam int DT = 4;
  localparam int BT = 1;
  localparam int FRAME = 4 * (DT + BT);

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic [15:0] value_in = '0;
  logic        load = 1'b0;
  logic [6:0]  seg_out;
  logic [3:0]  an_out;
  logic [1:0]  digit_sel;
  logic        pending;
  logic        frame_done;

  int total = 0;
  int bad = 0;
  logic [8:0] exp_q[$];

  scan_display_ctrl #(
    .N(16), .DIGIT_TICKS(DT), .BLANK_TICKS(BT), .LZ_SUPPRESS(1), .BLANK_SEG(7'h7F)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .value_in   (value_in),
    .load       (load),
    .seg_out    (seg_out),
    .an_out     (an_out),
    .digit_sel  (digit_sel),
    .pending    (pending),
    .frame_done (frame_done)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- check / model helpers ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] tbl [16];
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return tbl[n];
  endfunction

  function automatic logic [6:0] exp_seg(input logic [15:0] v, input int k);
    logic [15:0] upper;
    logic [15:0] sh;
    upper = v >> (4 * k);
    sh    = v >> (4 * k);
    if (k > 0 && upper == 16'h0) return 7'h7F;
    return hex7(sh[3:0]);
  endfunction

  // Push expectations for the first `cnt` digit slots (3 downward) of a frame.
  task automatic expect_digits(input logic [15:0] v, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      logic [1:0] k;
      k = 2'(3 - i);
      exp_q.push_back({k, exp_seg(v, 3 - i)});
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_load(input logic [15:0] v);
    value_in = v;
    load     = 1'b1;
    step();
    load     = 1'b0;
  endtask

  task automatic wait_frame(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!frame_done && n < 10 * FRAME);
    if (!frame_done) check("frame_timeout", 32'd0, 32'd1);
  endtask

  // ---------------- monitor ----------------
  logic [3:0] prev_an = 4'hF;
  int lit_len = 0;
  int blank_len = 0;
  bit seen_lit = 1'b0;

  always @(negedge clk) begin
    logic [1:0] idx;
    logic [8:0] e;
    check("one_digit_lit", 32'($countones(~an_out) <= 1), 32'd1);
    if (an_out != 4'hF) begin
      if (prev_an == 4'hF) begin
        idx = 2'd0;
        case (~an_out)
          4'b0010: idx = 2'd1;
          4'b0100: idx = 2'd2;
          4'b1000: idx = 2'd3;
          default: idx = 2'd0;
        endcase
        if (seen_lit) check("blank_len", blank_len, BT);
        check("digit_sel_vs_an", digit_sel, idx);
        if (exp_q.size() == 0) begin
          check("unexpected_digit", {idx, seg_out}, 32'h1FF);
        end else begin
          e = exp_q.pop_front();
          check("digit_seg", {idx, seg_out}, e);
        end
        lit_len = 1;
      end else begin
        lit_len++;
      end
      blank_len = 0;
    end else begin
      if (prev_an != 4'hF) begin
        if (en && !rst) check("lit_len", lit_len, DT);
        seen_lit = 1'b1;
      end
      blank_len++;
    end
    if (rst || !en) seen_lit = 1'b0;
    prev_an = an_out;
  end

  // ---------------- main sequence ----------------
  initial begin
    int n;
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_an", an_out, 4'hF);
    check("rst_seg", seg_out, 7'h7F);
    check("rst_digit_sel", digit_sel, 2'd3);
    check("rst_pending", pending, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);
    rst = 1'b0;
    step();

    // Load while dark goes straight to the display register.
    pulse_load(16'h1234);
    check("dark_load_pending", pending, 1'b0);
    check("dark_an", an_out, 4'hF);

    expect_digits(16'h1234, 4);
    en = 1'b1;
    wait_frame(n);
    check("first_frame_len", n, FRAME + 1);
    expect_digits(16'h1234, 4);

    // Load at cycle 3 of a frame is held until the frame boundary.
    repeat (2) step();
    pulse_load(16'hABCD);
    check("mid_frame_pending", pending, 1'b1);
    wait_frame(n);
    check("frame_len_a", n, FRAME - 3);
    check("pending_cleared", pending, 1'b0);
    expect_digits(16'hABCD, 4);

    // Two loads in one frame: last one wins.
    step();
    pulse_load(16'h1111);
    pulse_load(16'h2222);
    check("double_load_pending", pending, 1'b1);
    wait_frame(n);
    check("frame_len_b", n, FRAME - 3);
    expect_digits(16'h2222, 4);

    // Leading-zero suppression.
    step();
    pulse_load(16'h0050);
    wait_frame(n);
    check("frame_len_c", n, FRAME - 2);
    expect_digits(16'h0050, 4);
    step();
    pulse_load(16'h0000);
    wait_frame(n);
    check("frame_len_d", n, FRAME - 2);
    expect_digits(16'h0000, 4);

    // Load on the frame-end cycle bypasses the pending buffer.
    repeat (FRAME - 1) step();
    pulse_load(16'h0FED);
    check("fe_load_frame_done", frame_done, 1'b1);
    check("fe_load_pending", pending, 1'b0);

    // Drop en during digit 2: only digits 3 and 2 light in this frame.
    expect_digits(16'h0FED, 2);
    repeat (7) step();
    en = 1'b0;
    step();
    check("en_drop_an", an_out, 4'hF);
    check("en_drop_seg", seg_out, 7'h7F);
    check("en_drop_digit_sel", digit_sel, 2'd3);
    repeat (3) step();
    check("en_drop_queue_empty", exp_q.size(), 0);

    // Re-enable restarts at digit 3.
    expect_digits(16'h0FED, 4);
    en = 1'b1;
    wait_frame(n);
    check("restart_frame_len", n, FRAME + 1);

    // Reset during digit 2 with a value pending.
    expect_digits(16'h0FED, 2);
    repeat (2) step();
    pulse_load(16'h5A5A);
    check("pre_rst_pending", pending, 1'b1);
    repeat (4) step();
    rst = 1'b1;
    #1;
    check("async_rst_an", an_out, 4'hF);
    check("async_rst_seg", seg_out, 7'h7F);
    check("async_rst_pending", pending, 1'b0);
    check("async_rst_digit_sel", digit_sel, 2'd3);
    check("async_rst_queue_empty", exp_q.size(), 0);
    step();
    rst = 1'b0;
    expect_digits(16'h0000, 4);
    wait_frame(n);
    check("post_rst_frame_len", n, FRAME + 1);
    check("post_rst_pending", pending, 1'b0);

    en = 1'b0;
    repeat (3) step();
    check("final_queue_empty", exp_q.size(), 0);
    check("final_an", an_out, 4'hF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/scan_display_ctrl.md
Name: scan_display_ctrl

Overview:
- Time-multiplexed controller for the four-digit hexadecimal 7-segment display path.
- Drives the four digits of a 16-bit value through one shared segment bus plus per-digit enables, instead of four static segment buses.
- Instantiates one decoder_7_seg internally and double-buffers the displayed value, so a new value never tears mid-frame.
- Adds an anti-ghosting blank gap before each digit and optional leading-zero suppression.

Parameters:
N, 16, input value width; fixed at 16 (4 nibbles); any other value is unsupported.
DIGIT_TICKS, 50000, clk cycles each digit is lit (1 ms at 50 MHz); must be >= 1.
BLANK_TICKS, 500, clk cycles all digits are off before each digit is lit; must be >= 1.
LZ_SUPPRESS, 1, 1 = blank leading zero nibbles; digit 0 is always shown.
BLANK_SEG, 7'h7F, segment pattern driven while blanked (all segments off, active-low).

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
en  input  1  scan enable; 0 = display dark
value_in  input  N  new value to display
load  input  1  single-cycle strobe; captures value_in
seg_out  output  7  shared segment bus (decoder_7_seg pattern or BLANK_SEG)
an_out  output  4  digit enables, active-low; an_out[3] = value[15:12], an_out[0] = value[3:0]
digit_sel  output  2  index of the digit currently owning the bus
pending  output  1  1 = a loaded value is waiting for the next frame boundary
frame_done  output  1  one-cycle pulse at the end of each full 4-digit frame

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - State IDLE, tick counter 0, digit_sel = 3.
  - Display register 0, pending register 0, pending = 0.
  - an_out = 4'hF, seg_out = BLANK_SEG, frame_done = 0.
  - All outputs are registered.
- States:
  - IDLE: an_out = F, seg_out = BLANK_SEG. If en = 1, go to BLANK with digit_sel = 3 and counter 0.
  - BLANK: an_out = F, seg_out = BLANK_SEG for BLANK_TICKS cycles, then go to SHOW with counter 0.
  - SHOW: an_out[digit_sel] = 0, all other enables 1. seg_out = decode(nibble[digit_sel]), or BLANK_SEG if that digit is suppressed. Held for DIGIT_TICKS cycles.
- End of SHOW:
  - If digit_sel > 0: decrement digit_sel and go to BLANK.
  - If digit_sel = 0: frame end. Pulse frame_done for 1 cycle, set digit_sel = 3, go to BLANK.
- Frame timing: frame length is exactly 4*(BLANK_TICKS+DIGIT_TICKS) cycles. Digit order is 3, 2, 1, 0. The wrap from 0 back to 3 inserts no extra cycles.
- Load handshake:
  - load = 1 captures value_in into the pending register on that edge; pending = 1 on the next cycle.
  - A further load before transfer overwrites the pending register; last value wins.
- Transfer from pending register to display register:
  - Occurs on the frame-end cycle when pending = 1; pending clears on that same edge.
  - If load coincides with the frame-end cycle, the new value_in is transferred directly and pending stays 0.
- Disabled (en = 0): a load transfers straight to the display register on the strobe edge; pending is never set.
- Leading-zero suppression (LZ_SUPPRESS = 1):
  - Digit k (k = 3..1) is blanked iff the display-register nibbles k..3 are all zero.
  - Digit 0 is never suppressed, so value 0 shows "0".
  - Suppression uses the display register, never the pending register.
- en deasserted mid-frame: go to IDLE on the next edge with an_out = F. The counter resets, and the next enable restarts at digit 3.
- Reset mid-operation: all registers return to reset values immediately (asynchronous). Pending data is discarded.
- Ghosting: an_out is never 0 on two digits in the same cycle. Every change of the lit digit passes through at least BLANK_TICKS all-off cycles.

Test Plan (DIGIT_TICKS=4, BLANK_TICKS=1):
- Reset, then en = 1, load 16'h1234 with en = 0 beforehand -> frames show digits 3..0 as 1, 2, 3, 4. Each digit is lit 4 cycles after 1 blank cycle. frame_done pulses every 20 cycles.
- While scanning 16'h1234, load 16'hABCD at cycle 3 of a frame -> pending = 1. Current frame still shows 1234. The next frame shows ABCD and pending = 0 after the frame end.
- Two loads 16'h1111 then 16'h2222 within one frame -> the next frame shows 2222 only.
- LZ_SUPPRESS = 1, value 16'h0050 -> digits 3 and 2 are blanked (an_out still cycles, seg_out = 7'h7F); digits 1 and 0 show "5" and "0". Value 16'h0000 -> only digit 0 shows "0".
- Assert rst during SHOW of digit 2 -> an_out = F and seg_out = BLANK_SEG immediately; display register = 0 and pending = 0. After release, scanning restarts at digit 3.
- Assert check across all runs -> no cycle with more than one zero in an_out. Drop en mid-frame -> an_out = F on the next cycle.
